// File: rtl/fifo_rd_stream_adapter_if.sv
// fifo_rd_stream_adapter_if -- FIFO read side plus valid/ready stream bundle for the read adapter.
// Rev 1.0
`default_nettype none

interface fifo_rd_stream_adapter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 8
);
   localparam int c_CNT_W = $clog2(BUF_DEPTH) + 1;

   logic                  enable;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic                  fifo_read_en;
   logic [DATA_WIDTH-1:0] fifo_data_out;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [c_CNT_W-1:0]    m_count;
   logic                  err;

   modport master (
      input  enable, fifo_empty, fifo_read_en, fifo_data_out, m_ready,
      output fifo_pop, m_valid, m_data, m_count, err
   );

   modport slave (
      output enable, fifo_empty, fifo_read_en, fifo_data_out, m_ready,
      input  fifo_pop, m_valid, m_data, m_count, err
   );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter -- pops a fixed-latency FIFO and replays returned beats on a valid/ready stream.
// Rev 1.0
`default_nettype none

module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 4,
   parameter int BUF_DEPTH    = 8
) (
   input wire logic                 clk_i,
   input wire logic                 rst_ni,
   fifo_rd_stream_adapter_if.master bus
);
   localparam int                   c_PTR_W   = $clog2(BUF_DEPTH);
   localparam int                   c_CNT_W   = c_PTR_W + 1;
   localparam logic [c_CNT_W:0]     c_DEPTH   = (c_CNT_W + 1)'(BUF_DEPTH);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

   if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_depth_check
      $error("fifo_rd_stream_adapter: BUF_DEPTH must be a power of two >= 2");
   end
   if (BUF_DEPTH < READ_LATENCY + 1) begin : g_rate_check
      $warning("fifo_rd_stream_adapter: BUF_DEPTH < READ_LATENCY+1, stream cannot run at full rate");
   end

   logic [c_CNT_W-1:0]    outstanding_q, outstanding_d;
   logic [c_CNT_W-1:0]    occupancy_q, occupancy_d;
   logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

   logic [c_CNT_W:0]      in_use;
   logic                  pop;
   logic                  stray;
   logic                  capture;
   logic                  valid;
   logic                  xfer;

   // A pop is only issued when a slot is already reserved for its returning beat.
   always_comb begin
      in_use  = {1'b0, outstanding_q} + {1'b0, occupancy_q};
      pop     = rst_ni && bus.enable && !bus.fifo_empty && (in_use < c_DEPTH);
      stray   = bus.fifo_read_en && (outstanding_q == '0);
      capture = bus.fifo_read_en && !stray;
      valid   = (occupancy_q != '0);
      xfer    = valid && bus.m_ready;
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (pop && !capture) begin
         outstanding_d = outstanding_q + c_CNT_ONE;
      end else if (!pop && capture) begin
         outstanding_d = outstanding_q - c_CNT_ONE;
      end

      occupancy_d = occupancy_q;
      if (capture && !xfer) begin
         occupancy_d = occupancy_q + c_CNT_ONE;
      end else if (!capture && xfer) begin
         occupancy_d = occupancy_q - c_CNT_ONE;
      end

      wr_ptr_d = capture ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
      rd_ptr_d = xfer    ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
      err_d    = err_q | stray;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         occupancy_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         occupancy_q   <= occupancy_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         err_q         <= err_d;
      end
   end

   // Storage needs no reset: an entry is only visible once occupancy covers it.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         buf_q[wr_ptr_q] <= bus.fifo_data_out;
      end
   end

   assign bus.fifo_pop = pop;
   assign bus.m_valid  = valid;
   assign bus.m_data   = valid ? buf_q[rd_ptr_q] : '0;
   assign bus.m_count  = occupancy_q;
   assign bus.err      = err_q;

endmodule

`default_nettype wire
